// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the two-port SRAM encoder arbiter.
package sram_port_arbiter_pkg;

  // Sequencer states: one full encoder transaction per grant.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LAUNCH     = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_RESPOND    = 3'd4
  } arb_state_t;

  // Port identifiers as carried on the owner output.
  localparam logic ARB_PORT0 = 1'b0;
  localparam logic ARB_PORT1 = 1'b1;

  // Width of the starvation-guard counter (MAX_CONSEC up to 15).
  localparam int unsigned CONSEC_W = 4;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner selection for a two-port arbiter.
// SRAM_ARB_ROUND_ROBIN_EN: strict alternation driven by an rr pointer;
// otherwise fixed priority to port 0 with a consecutive-grant guard for port 1.
module sram_arb_pick
  import sram_port_arbiter_pkg::*;
`ifndef SRAM_ARB_ROUND_ROBIN_EN
#(
  parameter int MAX_CONSEC = 4
)
`endif
(
  input  logic [1:0]          i_reqs,
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  input  logic                i_rr,
`else
  input  logic [CONSEC_W-1:0] i_consec,
`endif
  output logic [1:0]          o_winner
);

  // One-hot winner; a lone requester always wins, contention is resolved by mode.
  always_comb begin
    o_winner = i_reqs;
    if (i_reqs == 2'b11) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      o_winner = i_rr ? 2'b10 : 2'b01;
`else
      o_winner = (i_consec == CONSEC_W'(MAX_CONSEC)) ? 2'b10 : 2'b01;
`endif
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of one spi_sram_encoder: grants one requester,
// sequences launch / busy / idle on the encoder, then returns read data.
// Build option SRAM_ARB_ROUND_ROBIN_EN selects round-robin instead of
// fixed priority with the MAX_CONSEC starvation guard.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int WORD_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 16,
  parameter int MAX_CONSEC    = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     p0_req,
  input  logic [ADDRESS_WIDTH-1:0] p0_addr,
  input  logic                     p0_we,
  input  logic [WORD_WIDTH-1:0]    p0_wdata,
  input  logic                     p1_req,
  input  logic [ADDRESS_WIDTH-1:0] p1_addr,
  input  logic                     p1_we,
  input  logic [WORD_WIDTH-1:0]    p1_wdata,
  output logic                     p0_gnt,
  output logic                     p1_gnt,
  output logic                     p0_done,
  output logic                     p1_done,
  output logic [WORD_WIDTH-1:0]    rdata,
  output logic                     mem_request,
  input  logic                     mem_busy,
  input  logic                     mem_initialized,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic                     mem_write_enable,
  output logic [WORD_WIDTH-1:0]    mem_wdata,
  input  logic [WORD_WIDTH-1:0]    mem_rdata,
  output logic                     owner
);

  arb_state_t               r_state;
  arb_state_t               w_next;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic                     r_we;
  logic [WORD_WIDTH-1:0]    r_wdata;
  logic [WORD_WIDTH-1:0]    r_rdata;
  logic                     r_owner;
  logic [1:0]               w_reqs;
  logic [1:0]               w_winner;
  logic                     w_can_grant;

  assign w_reqs = {p1_req, p0_req};

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic r_rr;

  sram_arb_pick u_pick (
    .i_reqs   (w_reqs),
    .i_rr     (r_rr),
    .o_winner (w_winner)
  );

  // rr pointer flips on every grant so contention alternates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              r_rr <= 1'b0;
    else if (p0_gnt || p1_gnt) r_rr <= ~r_rr;
  end
`else
  logic [CONSEC_W-1:0] r_consec;

  sram_arb_pick #(.MAX_CONSEC(MAX_CONSEC)) u_pick (
    .i_reqs   (w_reqs),
    .i_consec (r_consec),
    .o_winner (w_winner)
  );

  // Count port-0 grants made while port 1 waits; any port-1 grant or idle port 1 clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_consec <= '0;
    else if (p1_gnt || !p1_req)
      r_consec <= '0;
    else if (p0_gnt && (r_consec != CONSEC_W'(MAX_CONSEC)))
      r_consec <= r_consec + CONSEC_W'(1);
  end
`endif

  // Grant is combinational in IDLE; gating with reset_n keeps it low while reset is held.
  assign w_can_grant = reset_n && mem_initialized && !mem_busy && (|w_reqs);

  // Sequencer state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and pulse outputs for the sequencer.
  always_comb begin
    w_next      = r_state;
    p0_gnt      = 1'b0;
    p1_gnt      = 1'b0;
    p0_done     = 1'b0;
    p1_done     = 1'b0;
    mem_request = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_can_grant) begin
          p0_gnt = w_winner[0];
          p1_gnt = w_winner[1];
          w_next = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        mem_request = 1'b1;
        w_next      = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (mem_busy) w_next = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!mem_busy) w_next = ST_RESPOND;
      end
      ST_RESPOND: begin
        p0_done = (r_owner == ARB_PORT0);
        p1_done = (r_owner == ARB_PORT1);
        w_next  = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Latch the winner's command at grant; held unchanged until the next grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner <= ARB_PORT0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
    end else if (p0_gnt || p1_gnt) begin
      r_owner <= p1_gnt ? ARB_PORT1 : ARB_PORT0;
      r_addr  <= p1_gnt ? p1_addr  : p0_addr;
      r_we    <= p1_gnt ? p1_we    : p0_we;
      r_wdata <= p1_gnt ? p1_wdata : p0_wdata;
    end
  end

  // Capture encoder read data as busy falls; writes leave rdata untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_rdata <= '0;
    else if ((r_state == ST_WAIT_DONE) && !mem_busy && !r_we)
      r_rdata <= mem_rdata;
  end

  assign rdata            = r_rdata;
  assign mem_address      = r_addr;
  assign mem_write_enable = r_we;
  assign mem_wdata        = r_wdata;
  assign owner            = r_owner;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter with a behavioural encoder model.
module tb_sram_port_arbiter;

  localparam int WW = 16;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          p0_req, p1_req, p0_we, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [WW-1:0] p0_wdata, p1_wdata;
  logic          p0_gnt, p1_gnt, p0_done, p1_done;
  logic [WW-1:0] rdata;
  logic          mem_request, mem_busy, mem_initialized, mem_write_enable, owner;
  logic [AW-1:0] mem_address;
  logic [WW-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  int busy_len = 3;
  int busy_cnt;

  typedef struct {logic port; logic [WW-1:0] data;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  sram_port_arbiter #(.WORD_WIDTH(WW), .ADDRESS_WIDTH(AW), .MAX_CONSEC(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_we(p0_we), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_we(p1_we), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_done(p0_done), .p1_done(p1_done),
    .rdata(rdata), .mem_request(mem_request), .mem_busy(mem_busy),
    .mem_initialized(mem_initialized), .mem_address(mem_address),
    .mem_write_enable(mem_write_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  function automatic logic [WW-1:0] rd_value(input logic [AW-1:0] a);
    return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  // Encoder model: busy for busy_len cycles after a request, read data valid as busy falls.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_busy  <= 1'b0;
      busy_cnt  <= 0;
      mem_rdata <= '0;
    end else if (mem_request) begin
      mem_busy <= 1'b1;
      busy_cnt <= busy_len;
    end else if (mem_busy) begin
      if (busy_cnt <= 1) begin
        mem_busy <= 1'b0;
        if (!mem_write_enable) mem_rdata <= rd_value(mem_address);
      end else begin
        busy_cnt <= busy_cnt - 1;
      end
    end
  end

  task automatic idle_inputs();
    p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0;
    p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
  endtask

  // Waits (bounded) for any done pulse; returns at the negedge where it is seen.
  task automatic wait_done(input int budget, output bit got);
    got = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (p0_done || p1_done) begin got = 1; break; end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    mem_initialized = 1;
    reset_n = 1;
    #2 reset_n = 0;
    p0_req = 1; p0_addr = 16'h0ABC;
    @(negedge clk);
    checks++;
    if (p0_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b exp 0", p0_gnt); end
    checks++;
    if ({p1_gnt, p0_done, p1_done, mem_request, owner, mem_write_enable} !== 6'b0) begin
      errors++; $display("FAIL reset_ctl got %b exp 000000",
                        {p1_gnt, p0_done, p1_done, mem_request, owner, mem_write_enable});
    end
    checks++;
    if ({mem_address, mem_wdata, rdata} !== '0) begin
      errors++; $display("FAIL reset_data got %h/%h/%h exp 0", mem_address, mem_wdata, rdata);
    end
    @(posedge clk); #1;
    p0_req = 0;
    reset_n = 1;
  endtask

  task automatic test_init_gate();
    int g = 0, r = 0;
    bit got;
    exp_t e;
    @(posedge clk); #1;
    mem_initialized = 0;
    p1_req = 1; p1_addr = 16'h0020; p1_we = 0;
    repeat (50) begin
      @(negedge clk);
      if (p0_gnt || p1_gnt) g++;
      if (mem_request) r++;
    end
    checks++;
    if (g != 0) begin errors++; $display("FAIL init_gate_gnt got %0d exp 0", g); end
    checks++;
    if (r != 0) begin errors++; $display("FAIL init_gate_req got %0d exp 0", r); end
    @(posedge clk); #1;
    mem_initialized = 1;
    sb.push_back('{1'b1, rd_value(16'h0020)});
    @(negedge clk);
    checks++;
    if ({p1_gnt, p0_gnt} !== 2'b10) begin
      errors++; $display("FAIL init_release_gnt got %b exp 10", {p1_gnt, p0_gnt});
    end
    wait_done(100, got);
    checks++;
    if (!got) begin
      errors++; $display("FAIL init_done_timeout got none exp done");
    end else begin
      e = sb.pop_front();
      if ({p1_done, p0_done} !== {e.port, ~e.port} || rdata !== e.data) begin
        errors++; $display("FAIL init_done got p1/p0=%b rdata=%h exp port %0d rdata=%h",
                          {p1_done, p0_done}, rdata, e.port, e.data);
      end
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_read_beef();
    int cyc = 0, fall = -1, done_cyc = -1, p1bad = 0;
    bit seen = 0;
    exp_t e;
    busy_len = 20;
    @(posedge clk); #1;
    p0_req = 1; p0_addr = 16'h0010; p0_we = 0;
    sb.push_back('{1'b0, 16'hBEEF});
    @(negedge clk);
    checks++;
    if (p0_gnt !== 1'b1) begin errors++; $display("FAIL beef_gnt got %b exp 1", p0_gnt); end
    @(negedge clk);
    checks++;
    if (mem_request !== 1'b1 || mem_address !== 16'h0010) begin
      errors++; $display("FAIL beef_launch got req=%b addr=%h exp req=1 addr=0010",
                        mem_request, mem_address);
    end
    for (int i = 0; i < 100; i++) begin
      cyc++;
      @(negedge clk);
      if (p1_done) p1bad++;
      if (p0_done) begin done_cyc = cyc; break; end
      if (mem_busy) seen = 1;
      else if (seen && fall < 0) fall = cyc;
    end
    checks++;
    if (done_cyc < 0 || fall < 0 || done_cyc != fall + 1) begin
      errors++; $display("FAIL beef_latency got done=%0d exp fall+1=%0d", done_cyc, fall + 1);
    end
    checks++;
    if (p1bad != 0) begin errors++; $display("FAIL beef_p1_done got %0d exp 0", p1bad); end
    checks++;
    e = sb.pop_front();
    if (done_cyc < 0 || rdata !== e.data) begin
      errors++; $display("FAIL beef_rdata got %h exp %h", rdata, e.data);
    end
    @(posedge clk); #1;
    idle_inputs();
    busy_len = 3;
  endtask

  task automatic test_write_hold();
    int bad = 0;
    bit got = 0;
    exp_t e;
    @(posedge clk); #1;
    p1_req = 1; p1_addr = 16'h7FFF; p1_we = 1; p1_wdata = 16'h1234;
    sb.push_back('{1'b1, 16'hBEEF});
    @(negedge clk);
    checks++;
    if (p1_gnt !== 1'b1) begin errors++; $display("FAIL write_gnt got %b exp 1", p1_gnt); end
    @(posedge clk); #1;
    p1_addr = '0; p1_we = 0; p1_wdata = 16'hFFFF;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_write_enable !== 1'b1 || mem_wdata !== 16'h1234 ||
          mem_address !== 16'h7FFF || owner !== 1'b1) bad++;
      if (p0_done || p1_done) begin got = 1; break; end
    end
    checks++;
    if (!got || bad != 0) begin
      errors++; $display("FAIL write_hold got done=%0d unstable=%0d exp done=1 unstable=0", got, bad);
    end
    checks++;
    e = sb.pop_front();
    if ({p1_done, p0_done} !== {e.port, ~e.port} || rdata !== e.data) begin
      errors++; $display("FAIL write_rdata got p1/p0=%b rdata=%h exp port %0d rdata=%h",
                        {p1_done, p0_done}, rdata, e.port, e.data);
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_drop_after_gnt();
    int dones = 0, gnts = 0;
    logic [WW-1:0] seen_rdata = '0;
    exp_t e;
    @(posedge clk); #1;
    p0_req = 1; p0_addr = 16'h0040; p0_we = 0;
    sb.push_back('{1'b0, 16'h5A1A});
    @(negedge clk);
    checks++;
    if (p0_gnt !== 1'b1) begin errors++; $display("FAIL drop_gnt got %b exp 1", p0_gnt); end
    @(posedge clk); #1;
    p0_req = 0;
    repeat (40) begin
      @(negedge clk);
      if (p0_gnt || p1_gnt) gnts++;
      if (p1_done) dones += 100;
      if (p0_done) begin dones++; seen_rdata = rdata; end
    end
    checks++;
    if (dones != 1 || gnts != 0) begin
      errors++; $display("FAIL drop_done got dones=%0d gnts=%0d exp dones=1 gnts=0", dones, gnts);
    end
    checks++;
    e = sb.pop_front();
    if (seen_rdata !== e.data) begin
      errors++; $display("FAIL drop_rdata got %h exp %h", seen_rdata, e.data);
    end
  endtask

  task automatic test_back_to_back();
    int order[$];
    int exp_order[10];
    int both = 0;
    bit got;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif
    busy_len = 2;
    @(posedge clk); #1;
    reset_n = 0;
    p0_req = 1; p0_addr = 16'h0100;
    p1_req = 1; p1_addr = 16'h0200;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    for (int i = 0; i < 600 && order.size() < 10; i++) begin
      @(negedge clk);
      if (p0_gnt && p1_gnt) both++;
      else if (p0_gnt) order.push_back(0);
      else if (p1_gnt) order.push_back(1);
    end
    checks++;
    if (order.size() != 10 || both != 0) begin
      errors++; $display("FAIL b2b_count got %0d grants (%0d double) exp 10", order.size(), both);
    end
    for (int i = 0; i < 10 && i < order.size(); i++) begin
      checks++;
      if (order[i] != exp_order[i]) begin
        errors++; $display("FAIL b2b_order[%0d] got %0d exp %0d", i, order[i], exp_order[i]);
      end
    end
    @(posedge clk); #1;
    idle_inputs();
    wait_done(100, got);
    checks++;
    if (!got) begin errors++; $display("FAIL b2b_drain got none exp done"); end
    busy_len = 3;
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    int pulses = 0;
    busy_len = 20;
    @(posedge clk); #1;
    p1_req = 1; p1_addr = 16'h1234; p1_we = 1; p1_wdata = 16'hCAFE;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_busy) seen = 1;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (!seen || mem_address !== 16'h1234 || mem_write_enable !== 1'b1) begin
      errors++; $display("FAIL rstmid_setup got busy=%0d addr=%h we=%b exp busy=1 addr=1234 we=1",
                        seen, mem_address, mem_write_enable);
    end
    @(posedge clk); #1;
    reset_n = 0;
    #1;
    checks++;
    if ({p0_gnt, p1_gnt, p0_done, p1_done, mem_request, owner, mem_write_enable} !== 7'b0) begin
      errors++; $display("FAIL rstmid_ctl got %b exp 0000000",
                        {p0_gnt, p1_gnt, p0_done, p1_done, mem_request, owner, mem_write_enable});
    end
    checks++;
    if ({mem_address, mem_wdata, rdata} !== '0) begin
      errors++; $display("FAIL rstmid_data got %h/%h/%h exp 0", mem_address, mem_wdata, rdata);
    end
    p1_req = 0;
    @(posedge clk); #1;
    reset_n = 1;
    repeat (30) begin
      @(negedge clk);
      if (p0_done || p1_done || p0_gnt || p1_gnt || mem_request) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL rstmid_after got %0d pulses exp 0", pulses); end
    busy_len = 3;
  endtask

  initial begin
    test_reset();
    test_init_gate();
    test_read_beef();
    test_write_hold();
    test_drop_after_gnt();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
